// File: rtl/coprocessor_mdu_issue.sv
// Request queue and single-issue dispatcher sitting in front of the MDU
// control FSM. Buffers tagged multiply/divide requests, starts them one at a
// time, precomputes divide-by-zero / signed-overflow for the in-flight op and
// returns in-order tagged completions.
module coprocessor_mdu_issue #(
  parameter int DATA_WIDTH   = 64,
  parameter int QUEUE_DEPTH  = 4,
  parameter int TAG_WIDTH    = 4,
  parameter int MUL_CYCLES   = 4,
  parameter int DIV_CYCLES_W = 16,
  parameter int DIV_CYCLES_D = 31
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [2:0]                     req_op,
  input  logic [1:0]                     req_format,
  input  logic [DATA_WIDTH-1:0]          req_rs1,
  input  logic [DATA_WIDTH-1:0]          req_rs2,
  input  logic [TAG_WIDTH-1:0]           req_tag,
  input  logic                           mdu_ready,
  input  logic                           mdu_done,
  input  logic                           exception_raised,
  output logic                           mdu_start,
  output logic [2:0]                     mdu_operation,
  output logic [1:0]                     mdu_format,
  output logic [4:0]                     required_cycles,
  output logic [DATA_WIDTH-1:0]          op_a,
  output logic [DATA_WIDTH-1:0]          op_b,
  output logic                           divide_by_zero,
  output logic                           overflow_detected,
  output logic                           cmpl_valid,
  output logic [TAG_WIDTH-1:0]           cmpl_tag,
  output logic                           cmpl_exception,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {D_IDLE = 1'b0, D_WAIT = 1'b1} state_t;

  state_t r_state;
  state_t w_state_next;

  // Request storage (no reset needed: contents are only observed while count > 0)
  logic [2:0]            r_mem_op  [QUEUE_DEPTH];
  logic [1:0]            r_mem_fmt [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_rs1 [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_rs2 [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]  r_mem_tag [QUEUE_DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic r_dbz;
  logic r_ovf;
  logic r_cmpl_valid;
  logic [TAG_WIDTH-1:0] r_cmpl_tag;
  logic r_cmpl_exc;

  logic w_push;
  logic w_pop;
  logic w_issue;
  logic w_head_valid;
  logic [2:0]            w_head_op;
  logic [1:0]            w_head_fmt;
  logic [DATA_WIDTH-1:0] w_head_rs1;
  logic [DATA_WIDTH-1:0] w_head_rs2;
  logic [TAG_WIDTH-1:0]  w_head_tag;
  logic [4:0]            w_cycles;
  logic w_fmt_w;
  logic w_rs2_zero;
  logic w_rs1_min;
  logic w_rs2_ones;
  logic w_dbz;
  logic w_ovf;

  assign req_ready    = (r_count < CNT_W'(QUEUE_DEPTH));
  // Anything arriving together with a flush is dropped.
  assign w_push       = req_valid && req_ready && !flush;
  assign w_head_valid = (r_count != '0);

  assign w_head_op  = r_mem_op[r_rd_ptr];
  assign w_head_fmt = r_mem_fmt[r_rd_ptr];
  assign w_head_rs1 = r_mem_rs1[r_rd_ptr];
  assign w_head_rs2 = r_mem_rs2[r_rd_ptr];
  assign w_head_tag = r_mem_tag[r_rd_ptr];

  // Write accepted requests into the storage array
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wr_ptr]  <= req_op;
      r_mem_fmt[r_wr_ptr] <= req_format;
      r_mem_rs1[r_wr_ptr] <= req_rs1;
      r_mem_rs2[r_wr_ptr] <= req_rs2;
      r_mem_tag[r_wr_ptr] <= req_tag;
    end
  end

  // Pointer/count maintenance; flush keeps only an in-flight head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      if (r_state == D_WAIT && !w_pop) begin
        r_wr_ptr <= r_rd_ptr + PTR_W'(1);
        r_count  <= CNT_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
        r_wr_ptr <= r_rd_ptr + PTR_W'(w_pop);
        r_count  <= '0;
      end
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Cycle budget of the head operation
  always_comb begin
    w_cycles = 5'(MUL_CYCLES);
    if (w_head_op[2]) begin
      w_cycles = (w_head_fmt == 2'b00) ? 5'(DIV_CYCLES_W) : 5'(DIV_CYCLES_D);
    end
  end

  // Divide-by-zero / signed-overflow detection on the head operands
  always_comb begin
    w_fmt_w    = (w_head_fmt == 2'b00);
    w_rs2_zero = w_fmt_w ? (w_head_rs2[31:0] == 32'h0) : (w_head_rs2 == '0);
    w_rs1_min  = w_fmt_w ? (w_head_rs1[31:0] == 32'h8000_0000) : (w_head_rs1 == MOST_NEG);
    w_rs2_ones = w_fmt_w ? (w_head_rs2[31:0] == 32'hFFFF_FFFF) : (w_head_rs2 == '1);
    w_dbz      = w_head_op[2] && w_rs2_zero;
    // Only signed DIV (100) and REM (110) can overflow
    w_ovf      = w_head_op[2] && !w_head_op[0] && w_rs1_min && w_rs2_ones;
  end

  // Dispatcher state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= D_IDLE;
    else        r_state <= w_state_next;
  end

  // Dispatcher next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      D_IDLE: if (w_issue) w_state_next = D_WAIT;
      D_WAIT: if (mdu_done || exception_raised) w_state_next = D_IDLE;
      default: w_state_next = D_IDLE;
    endcase
  end

  // Dispatcher outputs: issue strobe and head pop
  always_comb begin
    w_issue   = 1'b0;
    w_pop     = 1'b0;
    mdu_start = 1'b0;
    if (r_state == D_IDLE) begin
      w_issue   = w_head_valid && mdu_ready && !flush;
      mdu_start = w_issue;
    end else begin
      w_pop = mdu_done || exception_raised;
    end
  end

  // Flags captured at issue, held while waiting, cleared on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbz <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_issue) begin
      r_dbz <= w_dbz;
      r_ovf <= w_ovf;
    end else if (w_pop) begin
      r_dbz <= 1'b0;
      r_ovf <= 1'b0;
    end
  end

  // Completion report one cycle after the pop; exception wins over done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmpl_valid <= 1'b0;
      r_cmpl_tag   <= '0;
      r_cmpl_exc   <= 1'b0;
    end else begin
      r_cmpl_valid <= w_pop;
      if (w_pop) begin
        r_cmpl_tag <= w_head_tag;
        r_cmpl_exc <= exception_raised;
      end
    end
  end

  assign mdu_operation     = w_head_valid ? w_head_op  : 3'b000;
  assign mdu_format        = w_head_valid ? w_head_fmt : 2'b00;
  assign required_cycles   = w_head_valid ? w_cycles   : 5'd0;
  assign op_a              = w_head_valid ? w_head_rs1 : '0;
  assign op_b              = w_head_valid ? w_head_rs2 : '0;
  assign divide_by_zero    = r_dbz;
  assign overflow_detected = r_ovf;
  assign cmpl_valid        = r_cmpl_valid;
  assign cmpl_tag          = r_cmpl_tag;
  assign cmpl_exception    = r_cmpl_exc;
  assign queue_count       = r_count;

endmodule

// File: tb/tb_coprocessor_mdu_issue.sv
// Bench for coprocessor_mdu_issue: vector table of single ops, MDU FSM model,
// completion scoreboard, plus full-queue, flush and mid-op reset sequences.
module tb_coprocessor_mdu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [1:0]  req_format;
  logic [63:0] req_rs1;
  logic [63:0] req_rs2;
  logic [3:0]  req_tag;
  logic        mdu_ready;
  logic        mdu_done;
  logic        exception_raised;
  logic        mdu_start;
  logic [2:0]  mdu_operation;
  logic [1:0]  mdu_format;
  logic [4:0]  required_cycles;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        divide_by_zero;
  logic        overflow_detected;
  logic        cmpl_valid;
  logic [3:0]  cmpl_tag;
  logic        cmpl_exception;
  logic [2:0]  queue_count;

  coprocessor_mdu_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_format(req_format), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .mdu_ready(mdu_ready), .mdu_done(mdu_done), .exception_raised(exception_raised),
    .mdu_start(mdu_start), .mdu_operation(mdu_operation), .mdu_format(mdu_format),
    .required_cycles(required_cycles), .op_a(op_a), .op_b(op_b),
    .divide_by_zero(divide_by_zero), .overflow_detected(overflow_detected),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_exception(cmpl_exception),
    .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  fmt;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [3:0]  tag;
    logic [4:0]  cyc;
    logic        dbz;
    logic        ovf;
    logic        exc;
    logic        both;
    int          lat;
  } vec_t;

  typedef struct {
    logic [3:0] tag;
    logic       exc;
  } cmpl_t;

  vec_t  vecs [11];
  vec_t  issue_q [$];
  cmpl_t cmpl_q [$];

  int   n_cmp = 0;
  int   n_fail = 0;
  bit   busy = 0;
  int   cnt = 0;
  vec_t cur;
  int   in_flight = 0;
  int   start_cnt = 0;
  int   cmpl_cnt = 0;

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] fmt,
                              input logic [63:0] rs1, input logic [63:0] rs2,
                              input logic [3:0] tag, input logic [4:0] cyc,
                              input logic dbz, input logic ovf, input logic exc,
                              input logic both, input int lat);
    vec_t v;
    v.op = op; v.fmt = fmt; v.rs1 = rs1; v.rs2 = rs2; v.tag = tag; v.cyc = cyc;
    v.dbz = dbz; v.ovf = ovf; v.exc = exc; v.both = both; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // One clock: sample at negedge (scoreboard + MDU model), respond after posedge
  task automatic tick();
    logic nd, ne;
    cmpl_t c;
    nd = 1'b0;
    ne = 1'b0;
    @(negedge clk);
    if (cmpl_valid) begin
      cmpl_cnt++;
      $display("completion tag=%0d exc=%0d", cmpl_tag, cmpl_exception);
      if (cmpl_q.size() == 0) begin
        fail_now("unexpected_cmpl");
      end else begin
        c = cmpl_q.pop_front();
        check("cmpl_tag", 64'(cmpl_tag), 64'(c.tag));
        check("cmpl_exc", 64'(cmpl_exception), 64'(c.exc));
        check("idle_dbz", 64'(divide_by_zero), 64'd0);
        check("idle_ovf", 64'(overflow_detected), 64'd0);
        in_flight--;
      end
    end
    if (busy) begin
      check("wait_dbz", 64'(divide_by_zero), 64'(cur.dbz));
      check("wait_ovf", 64'(overflow_detected), 64'(cur.ovf));
      check("wait_op", 64'(mdu_operation), 64'(cur.op));
      check("wait_cycles", 64'(required_cycles), 64'(cur.cyc));
      check("wait_op_a", op_a, cur.rs1);
      check("wait_op_b", op_b, cur.rs2);
      cnt--;
      if (cnt <= 0) begin
        if (cur.exc) begin ne = 1'b1; nd = cur.both; end
        else nd = 1'b1;
        busy = 0;
      end
    end
    if (mdu_start) begin
      start_cnt++;
      if (issue_q.size() == 0) begin
        fail_now("unexpected_start");
      end else begin
        cur = issue_q.pop_front();
        check("start_cycles", 64'(required_cycles), 64'(cur.cyc));
        check("start_op", 64'(mdu_operation), 64'(cur.op));
        check("start_fmt", 64'(mdu_format), 64'(cur.fmt));
        check("start_dbz_low", 64'(divide_by_zero), 64'd0);
        busy = 1;
        cnt = cur.lat;
        in_flight++;
      end
    end
    @(posedge clk);
    #1;
    mdu_done = nd;
    exception_raised = ne;
  endtask

  task automatic push_req(input vec_t v);
    int k;
    k = 0;
    while (!req_ready && k < 50) begin tick(); k++; end
    if (!req_ready) fail_now("push_ready_timeout");
    req_op = v.op; req_format = v.fmt; req_rs1 = v.rs1; req_rs2 = v.rs2; req_tag = v.tag;
    req_valid = 1'b1;
    issue_q.push_back(v);
    cmpl_q.push_back('{tag: v.tag, exc: v.exc});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (cmpl_q.size() > 0 && k < budget) begin tick(); k++; end
    if (cmpl_q.size() > 0) fail_now("drain_timeout");
  endtask

  task automatic wait_in_flight();
    int k;
    k = 0;
    while (in_flight == 0 && k < 30) begin tick(); k++; end
    if (in_flight == 0) fail_now("issue_timeout");
  endtask

  task automatic check_reset_outputs(input string tagname);
    check({tagname, "_req_ready"}, 64'(req_ready), 64'd1);
    check({tagname, "_start"}, 64'(mdu_start), 64'd0);
    check({tagname, "_count"}, 64'(queue_count), 64'd0);
    check({tagname, "_cmpl_valid"}, 64'(cmpl_valid), 64'd0);
    check({tagname, "_cmpl_tag"}, 64'(cmpl_tag), 64'd0);
    check({tagname, "_dbz"}, 64'(divide_by_zero), 64'd0);
    check({tagname, "_ovf"}, 64'(overflow_detected), 64'd0);
    check({tagname, "_cycles"}, 64'(required_cycles), 64'd0);
    check({tagname, "_op"}, 64'(mdu_operation), 64'd0);
    check({tagname, "_op_a"}, op_a, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    vec_t v;
    // op fmt rs1 rs2 tag cycles dbz ovf exc both latency
    vecs[0]  = mk(3'b000, 2'b00, 64'd6, 64'd7, 4'd3, 5'd4, 0, 0, 0, 0, 8);
    vecs[1]  = mk(3'b100, 2'b01, 64'd100, 64'd0, 4'd5, 5'd31, 1, 0, 1, 0, 6);
    vecs[2]  = mk(3'b101, 2'b00, 64'd5, 64'h1_0000_0000, 4'd6, 5'd16, 1, 0, 1, 0, 5);
    vecs[3]  = mk(3'b100, 2'b00, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF, 4'd7, 5'd16, 0, 1, 0, 0, 4);
    vecs[4]  = mk(3'b101, 2'b00, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF, 4'd8, 5'd16, 0, 0, 0, 0, 4);
    vecs[5]  = mk(3'b110, 2'b01, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'd9, 5'd31, 0, 1, 0, 0, 3);
    vecs[6]  = mk(3'b010, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'd1, 5'd4, 0, 0, 0, 0, 2);
    vecs[7]  = mk(3'b111, 2'b01, 64'd9, 64'd0, 4'd2, 5'd31, 1, 0, 1, 0, 3);
    vecs[8]  = mk(3'b100, 2'b01, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4, 5'd31, 0, 0, 0, 0, 3);
    vecs[9]  = mk(3'b110, 2'b00, 64'h8000_0000, 64'hFFFF_FFFF, 4'd10, 5'd16, 0, 1, 0, 0, 3);
    vecs[10] = mk(3'b000, 2'b10, 64'd3, 64'd4, 4'd11, 5'd4, 0, 0, 1, 1, 2);

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_format = '0;
    req_rs1 = '0; req_rs2 = '0; req_tag = '0; mdu_ready = 1'b1;
    mdu_done = 1'b0; exception_raised = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Single-op vectors
    for (int i = 0; i < 11; i++) begin
      s0 = start_cnt;
      push_req(vecs[i]);
      drain(80);
      tick();
      check("vec_starts", 64'(start_cnt - s0), 64'd1);
      check("vec_count_zero", 64'(queue_count), 64'd0);
    end

    // Fill the queue with the MDU held busy
    mdu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = mk(3'b000, 2'b00, 64'(i + 1), 64'(i + 2), 4'(i), 5'd4, 0, 0, 0, 0, 3);
      push_req(v);
    end
    check("full_req_ready", 64'(req_ready), 64'd0);
    check("full_count", 64'(queue_count), 64'd4);
    req_valid = 1'b1; req_tag = 4'd9; req_op = 3'b001;
    tick();
    check("full_refuse", 64'(queue_count), 64'd4);
    mdu_ready = 1'b1;
    begin
      int k;
      k = 0;
      while (!mdu_done && !exception_raised && k < 30) begin tick(); k++; end
      if (!mdu_done && !exception_raised) fail_now("full_done_timeout");
    end
    tick();
    req_valid = 1'b0;
    check("full_pop_refuse", 64'(queue_count), 64'd3);
    drain(100);
    tick();
    check("full_drained", 64'(queue_count), 64'd0);

    // Flush while the first of three is in flight; a same-cycle push is dropped
    mdu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = mk(3'b100, 2'b01, 64'd50, 64'(i + 3), 4'(12 + i), 5'd31, 0, 0, 0, 0, 8);
      push_req(v);
    end
    s0 = start_cnt;
    mdu_ready = 1'b1;
    wait_in_flight();
    flush = 1'b1;
    req_valid = 1'b1; req_tag = 4'd15;
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    issue_q.delete();
    while (cmpl_q.size() > in_flight) cmpl_q.pop_back();
    check("flush_count", 64'(queue_count), 64'd1);
    drain(40);
    repeat (6) tick();
    check("flush_starts", 64'(start_cnt - s0), 64'd1);
    check("flush_count_zero", 64'(queue_count), 64'd0);

    // Reset in the middle of a long divide
    v = mk(3'b100, 2'b01, 64'd77, 64'd0, 4'd6, 5'd31, 1, 0, 1, 0, 20);
    push_req(v);
    wait_in_flight();
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    busy = 0; in_flight = 0; issue_q.delete(); cmpl_q.delete();
    mdu_done = 1'b0; exception_raised = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    s0 = cmpl_cnt;
    repeat (15) tick();
    check("post_rst_no_cmpl", 64'(cmpl_cnt - s0), 64'd0);
    check("post_rst_count", 64'(queue_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/coprocessor_mdu_issue.md
Name: coprocessor_mdu_issue

Overview:
Request queue and dispatcher directly upstream of the coprocessor MDU control FSM. It buffers multiply/divide requests from the coprocessor pipeline and issues them one at a time with mdu_start. For each issued operation it supplies the operation, format and required cycle count, and it pre-computes divide-by-zero and signed-overflow flags. It reports tagged completions back to the pipeline.

Parameters:
DATA_WIDTH, 64, operand width
QUEUE_DEPTH, 4, request FIFO entries; power of 2, minimum 2
TAG_WIDTH, 4, request tag width
MUL_CYCLES, 4, required_cycles for multiply ops (op[2]=0)
DIV_CYCLES_W, 16, required_cycles for divide ops when format=2'b00 (32-bit)
DIV_CYCLES_D, 31, required_cycles for divide ops for any other format (64-bit)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  drop all queued, not-yet-issued requests
req_valid  in  1  request present
req_ready  out  1  queue can accept a request
req_op  in  3  operation (000 MUL, 001 MULH, 010 MULHU, 011 MULHSU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
req_format  in  2  00 = 32-bit word; otherwise 64-bit
req_rs1  in  DATA_WIDTH  dividend / multiplicand
req_rs2  in  DATA_WIDTH  divisor / multiplier
req_tag  in  TAG_WIDTH  request identifier
mdu_ready  in  1  FSM idle
mdu_done  in  1  FSM completion pulse
exception_raised  in  1  FSM exception pulse
mdu_start  out  1  start pulse to FSM
mdu_operation  out  3  op of in-flight/head entry
mdu_format  out  2  format of in-flight/head entry
required_cycles  out  5  compute cycles for in-flight/head entry
op_a  out  DATA_WIDTH  rs1 of in-flight/head entry
op_b  out  DATA_WIDTH  rs2 of in-flight/head entry
divide_by_zero  out  1  in-flight op divides by zero
overflow_detected  out  1  in-flight op is signed MIN/-1
cmpl_valid  out  1  completion pulse
cmpl_tag  out  TAG_WIDTH  tag of completed op
cmpl_exception  out  1  completion ended in exception
queue_count  out  $clog2(QUEUE_DEPTH)+1  occupied entries

Behaviour:
- Reset values: all outputs 0, except req_ready=1. FIFO pointers, count and dispatcher state are cleared. Reset mid-operation discards the in-flight op with no completion.
- FIFO:
  - Push when req_valid && req_ready. req_ready = (count < QUEUE_DEPTH).
  - Push and pop in the same cycle leaves count unchanged.
  - There is no bypass: a request is issued no earlier than the cycle after it is pushed.
  - Pointers wrap modulo QUEUE_DEPTH.
- Dispatcher FSM, states D_IDLE and D_WAIT:
  - D_IDLE: when count>0 && mdu_ready && !flush, assert mdu_start for exactly 1 cycle and go to D_WAIT. The head entry stays in the FIFO.
  - D_WAIT: mdu_start=0. On mdu_done or exception_raised: pop the head, go to D_IDLE, and in the next cycle pulse cmpl_valid=1 with cmpl_tag = head tag and cmpl_exception = exception_raised.
  - If mdu_done and exception_raised are both high, treat it as an exception.
  - A new issue may occur in the cycle after the pop (back-to-back issue latency is 1 idle cycle).
- mdu_operation, mdu_format, required_cycles, op_a and op_b reflect the head entry. They are stable for the whole time in D_WAIT.
- required_cycles:
  - MUL_CYCLES when op[2]=0.
  - Otherwise DIV_CYCLES_W when format=00, else DIV_CYCLES_D.
- Flags are registered at issue, held through D_WAIT, and 0 in D_IDLE. They must never be high while nothing is in flight.
  - divide_by_zero = op[2] && (rs2 == 0). For format 00 only the low 32 bits are compared.
  - overflow_detected = op in {100, 110} && rs1 == most-negative && rs2 == all-ones. For format 00 this is evaluated on the low 32 bits (rs1[31:0] = 0x8000_0000).
  - Unsigned ops (101, 111) never raise overflow.
- flush:
  - Removes all non-issued entries. In D_WAIT the head is kept, count becomes 1, and the in-flight op completes and reports normally.
  - In D_IDLE count becomes 0.
  - A push in the same cycle as flush is discarded.
  - flush suppresses issue in that cycle.
- Completions are in order. Exactly one cmpl_valid per issued op.

Test Plan:
- Reset, then push MUL tag=3 rs1=6 rs2=7; FSM model returns mdu_done 8 cycles after start -> one mdu_start pulse with required_cycles=4; cmpl_valid 1 cycle after mdu_done with cmpl_tag=3, cmpl_exception=0; queue_count back to 0.
- DIV format=01 rs2=0 tag=5 -> divide_by_zero=1 from the cycle after mdu_start until exception_raised; required_cycles=31; cmpl_exception=1, tag=5. Repeat with DIVU format=00 rs2=0x1_0000_0000 -> divide_by_zero=1, required_cycles=16.
- DIV format=00 rs1=0xFFFF_FFFF_8000_0000 rs2=0xFFFF_FFFF -> overflow_detected=1. Same operands with DIVU -> overflow_detected=0. REM format=01 rs1=0x8000_0000_0000_0000 rs2=all-ones -> overflow_detected=1.
- Fill 4 requests (tags 0-3) with mdu_ready held low -> req_ready=0 and queue_count=4; a 5th req_valid is not accepted. Release mdu_ready -> 4 in-order completions with tags 0,1,2,3; a push in the cycle of a pop while full is refused.
- Queue 3 requests, issue the first, assert flush during D_WAIT -> queue_count=1; only the first tag completes; no further mdu_start.
- Assert rst_n=0 mid-D_WAIT -> all outputs 0 and req_ready=1; no cmpl_valid after reset release.
